// File: rtl/rl_queue_wr_arbiter_pkg.sv
// Shared types and helpers for the queue write arbiter and its round-robin picker.
package rl_queue_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Tag width: max(1, $clog2(n)) so a 2-source arbiter still gets a 1-bit ID.
  function automatic int unsigned rr_idbits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rl_queue_wr_arbiter_if.sv
// Producer/queue side of the write arbiter: requests, payloads, acks and the queue write port.
interface rl_queue_wr_arbiter_if
  import rl_queue_arb_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned DBITS      = 32
);
  localparam int unsigned IDBITS = rr_idbits(REQUESTERS);

  logic [REQUESTERS-1:0]            req_i;
  logic [REQUESTERS-1:0][DBITS-1:0] d_i;
  logic [REQUESTERS-1:0]            ack_o;
  logic                             q_we_o;
  logic [IDBITS+DBITS-1:0]          q_d_o;
  logic                             q_full_i;

  modport slave  (input  req_i, d_i, q_full_i, output ack_o, q_we_o, q_d_o);
  modport master (output req_i, d_i, q_full_i, input  ack_o, q_we_o, q_d_o);

endinterface

// File: rtl/rl_queue_wr_arbiter_rr_picker.sv
// Rotating priority encoder: first set request at or above i_ptr, wrapping N-1 -> 0.
module rl_rr_picker
  import rl_queue_arb_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = rr_idbits(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  int unsigned w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/rl_queue_wr_arbiter.sv
// Round-robin write arbiter sharing one queue between REQUESTERS producers, bursts capped at MAX_BURST.
module rl_queue_wr_arbiter
  import rl_queue_arb_pkg::*;
#(
  parameter  int unsigned REQUESTERS = 4,
  parameter  int unsigned DBITS      = 32,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned IDBITS     = rr_idbits(REQUESTERS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 ena_i,
  rl_queue_wr_arbiter_if.slave bus,
  output logic [IDBITS-1:0]    gnt_id_o,
  output logic                 busy_o
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  arb_state_t        r_state;
  logic [IDBITS-1:0] r_owner;
  logic [IDBITS-1:0] r_rr_ptr;
  logic [BCW-1:0]    r_bcnt;
  logic              r_busy;

  logic              w_found;
  logic [IDBITS-1:0] w_pick;
  logic              w_req_own;
  logic              w_wr;
  logic              w_exit;
  logic [IDBITS-1:0] w_next_ptr;

  rl_rr_picker #(.N(REQUESTERS)) u_picker (
    .i_req   (bus.req_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    w_req_own  = bus.req_i[r_owner];
    w_wr       = (r_state == BURST) && w_req_own && !bus.q_full_i && ena_i;
    // Owner dropping its request ends the burst even while the queue is full.
    w_exit     = (r_state == BURST) && ena_i &&
                 (!w_req_own || (w_wr && (r_bcnt == BCW'(MAX_BURST - 1))));
    w_next_ptr = (r_owner == IDBITS'(REQUESTERS - 1)) ? '0 : r_owner + IDBITS'(1);
  end

  assign bus.q_we_o = w_wr;
  assign bus.ack_o  = w_wr ? (REQUESTERS'(1) << r_owner) : '0;
  assign bus.q_d_o  = {r_owner, bus.d_i[r_owner]};
  assign gnt_id_o   = r_owner;
  assign busy_o     = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bcnt   <= '0;
      r_busy   <= 1'b0;
    end else if (clr_i) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bcnt   <= '0;
      r_busy   <= 1'b0;
    end else if (ena_i) begin
      case (r_state)
        IDLE: begin
          if (w_found && !bus.q_full_i) begin
            r_owner <= w_pick;
            r_bcnt  <= '0;
            r_state <= BURST;
            r_busy  <= 1'b1;
          end
        end
        BURST: begin
          if (w_exit) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end else if (w_wr) begin
            r_bcnt <= r_bcnt + BCW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rl_queue_wr_arbiter.sv
// Cycle-by-cycle vector bench for rl_queue_wr_arbiter (4 sources, 32-bit payload, bursts of 4).
module tb_rl_queue_wr_arbiter;

  logic       clk;
  logic       rst_ni;
  logic       clr;
  logic       ena;
  logic [1:0] gnt_id;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  rl_queue_wr_arbiter_if #(.REQUESTERS(4), .DBITS(32)) bus ();

  rl_queue_wr_arbiter #(.REQUESTERS(4), .DBITS(32), .MAX_BURST(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .clr_i    (clr),
    .ena_i    (ena),
    .bus      (bus.slave),
    .gnt_id_o (gnt_id),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ena;
    logic [3:0] req;
    logic       full;
    logic [3:0] ack;
    logic [1:0] gnt;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] dat [4];

  task automatic add(input int n, input logic c, input logic e, input logic [3:0] r,
                     input logic f, input logic [3:0] a, input logic [1:0] g, input logic b);
    vec_t v;
    v.clr = c; v.ena = e; v.req = r; v.full = f; v.ack = a; v.gnt = g; v.busy = b;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [1:0] g, input logic b);
    logic [33:0] exp_qd;
    exp_qd = {g, dat[g]};
    chk({tag, " ack"},  64'(bus.ack_o),  64'(a));
    chk({tag, " we"},   64'(bus.q_we_o), 64'(|a));
    chk({tag, " gnt"},  64'(gnt_id),     64'(g));
    chk({tag, " busy"}, 64'(busy),       64'(b));
    chk({tag, " qd"},   64'(bus.q_d_o),  64'(exp_qd));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      dat[k] = 32'hA5A5_0000 + 32'(k * 17);
      bus.d_i[k] = dat[k];
    end
    rst_ni = 1'b0; clr = 1'b0; ena = 1'b1;
    bus.req_i = '0; bus.q_full_i = 1'b0;

    // single source 2: arbitrate, 4 writes, idle, re-grant, early drop
    add(2, 0,1,4'b0000,0, 4'b0000,2'd0,0);
    add(1, 0,1,4'b0100,0, 4'b0000,2'd0,0);
    add(4, 0,1,4'b0100,0, 4'b0100,2'd2,1);
    add(1, 0,1,4'b0100,0, 4'b0000,2'd2,0);
    add(1, 0,1,4'b0100,0, 4'b0100,2'd2,1);
    add(1, 0,1,4'b0000,0, 4'b0000,2'd2,1);
    add(1, 0,1,4'b0000,0, 4'b0000,2'd2,0);
    add(1, 1,1,4'b0000,0, 4'b0000,2'd2,0);
    // rotation 0,1,2,3,0
    add(1, 0,1,4'b1111,0, 4'b0000,2'd0,0);
    add(4, 0,1,4'b1111,0, 4'b0001,2'd0,1);
    add(1, 0,1,4'b1111,0, 4'b0000,2'd0,0);
    add(4, 0,1,4'b1111,0, 4'b0010,2'd1,1);
    add(1, 0,1,4'b1111,0, 4'b0000,2'd1,0);
    add(4, 0,1,4'b1111,0, 4'b0100,2'd2,1);
    add(1, 0,1,4'b1111,0, 4'b0000,2'd2,0);
    add(4, 0,1,4'b1111,0, 4'b1000,2'd3,1);
    add(1, 0,1,4'b1111,0, 4'b0000,2'd3,0);
    // backpressure mid-burst on source 0
    add(1, 0,1,4'b1111,0, 4'b0001,2'd0,1);
    add(3, 0,1,4'b1111,1, 4'b0000,2'd0,1);
    add(3, 0,1,4'b1111,0, 4'b0001,2'd0,1);
    add(1, 0,1,4'b1111,0, 4'b0000,2'd0,0);
    // early release of source 1, then 3 before 0
    add(2, 0,1,4'b1111,0, 4'b0010,2'd1,1);
    add(1, 0,1,4'b1001,0, 4'b0000,2'd1,1);
    add(1, 0,1,4'b1001,0, 4'b0000,2'd1,0);
    add(1, 0,1,4'b1001,0, 4'b1000,2'd3,1);
    // clear mid-burst, then enable gaps
    add(1, 1,1,4'b1001,0, 4'b1000,2'd3,1);
    add(1, 0,1,4'b1001,0, 4'b0000,2'd0,0);
    add(1, 0,1,4'b1001,0, 4'b0001,2'd0,1);
    add(2, 0,0,4'b1001,0, 4'b0000,2'd0,1);
    add(3, 0,1,4'b1001,0, 4'b0001,2'd0,1);
    add(1, 0,1,4'b0000,0, 4'b0000,2'd0,0);
    // full queue blocks arbitration
    add(1, 0,1,4'b0010,1, 4'b0000,2'd0,0);
    add(1, 0,1,4'b0010,0, 4'b0000,2'd0,0);
    add(1, 0,1,4'b0010,0, 4'b0010,2'd1,1);

    repeat (2) @(negedge clk);
    #1 chk_all("reset", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      clr = tbl[i].clr; ena = tbl[i].ena;
      bus.req_i = tbl[i].req; bus.q_full_i = tbl[i].full;
      #1 chk_all($sformatf("v%0d", i), tbl[i].ack, tbl[i].gnt, tbl[i].busy);
    end

    // asynchronous reset mid-burst, then re-arbitration of the same source
    @(negedge clk);
    clr = 1'b0; ena = 1'b1; bus.req_i = 4'b0010; bus.q_full_i = 1'b0;
    #1 chk_all("pre_arst", 4'b0010, 2'd1, 1'b1);
    #2 rst_ni = 1'b0;
    #1 chk_all("arst", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk_all("arst_idle", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    #1 chk_all("arst_regrant", 4'b0010, 2'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
